// File: rtl/main_memory_arbiter_pkg.sv
// Shared encodings and default widths for the main-memory arbiter.
package main_memory_arbiter_pkg;

  localparam int unsigned DATAWIDTH_ADDR_DEF = 16;
  localparam int unsigned DATAWIDTH_DATA_DEF = 32;
  localparam int unsigned DATAWIDTH_WAIT_DEF = 4;
  localparam int unsigned WAIT_STATES_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LD  = 1'b1
  } owner_t;

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Requester and memory-port bundle; slave is the arbiter, master is its surroundings.
interface main_memory_arbiter_if
  import main_memory_arbiter_pkg::*;
#(
  parameter int unsigned DATAWIDTH_ADDR = DATAWIDTH_ADDR_DEF,
  parameter int unsigned DATAWIDTH_DATA = DATAWIDTH_DATA_DEF
);

  logic                      MAIN_MEMORY_ARBITER_CpuRD_In;
  logic                      MAIN_MEMORY_ARBITER_CpuWR_In;
  logic [DATAWIDTH_ADDR-1:0] MAIN_MEMORY_ARBITER_CpuAddr_InBus;
  logic [DATAWIDTH_DATA-1:0] MAIN_MEMORY_ARBITER_CpuWData_InBus;
  logic                      MAIN_MEMORY_ARBITER_CpuACK_Out;
  logic                      MAIN_MEMORY_ARBITER_LdReq_In;
  logic                      MAIN_MEMORY_ARBITER_LdWE_In;
  logic [DATAWIDTH_ADDR-1:0] MAIN_MEMORY_ARBITER_LdAddr_InBus;
  logic [DATAWIDTH_DATA-1:0] MAIN_MEMORY_ARBITER_LdWData_InBus;
  logic                      MAIN_MEMORY_ARBITER_LdACK_Out;
  logic [DATAWIDTH_DATA-1:0] MAIN_MEMORY_ARBITER_RData_OutBus;
  logic                      MAIN_MEMORY_ARBITER_MemCS_Out;
  logic                      MAIN_MEMORY_ARBITER_MemWE_Out;
  logic [DATAWIDTH_ADDR-1:0] MAIN_MEMORY_ARBITER_MemAddr_OutBus;
  logic [DATAWIDTH_DATA-1:0] MAIN_MEMORY_ARBITER_MemWData_OutBus;
  logic [DATAWIDTH_DATA-1:0] MAIN_MEMORY_ARBITER_MemRData_InBus;

  modport slave (
    input  MAIN_MEMORY_ARBITER_CpuRD_In, MAIN_MEMORY_ARBITER_CpuWR_In,
           MAIN_MEMORY_ARBITER_CpuAddr_InBus, MAIN_MEMORY_ARBITER_CpuWData_InBus,
           MAIN_MEMORY_ARBITER_LdReq_In, MAIN_MEMORY_ARBITER_LdWE_In,
           MAIN_MEMORY_ARBITER_LdAddr_InBus, MAIN_MEMORY_ARBITER_LdWData_InBus,
           MAIN_MEMORY_ARBITER_MemRData_InBus,
    output MAIN_MEMORY_ARBITER_CpuACK_Out, MAIN_MEMORY_ARBITER_LdACK_Out,
           MAIN_MEMORY_ARBITER_RData_OutBus, MAIN_MEMORY_ARBITER_MemCS_Out,
           MAIN_MEMORY_ARBITER_MemWE_Out, MAIN_MEMORY_ARBITER_MemAddr_OutBus,
           MAIN_MEMORY_ARBITER_MemWData_OutBus
  );

  modport master (
    output MAIN_MEMORY_ARBITER_CpuRD_In, MAIN_MEMORY_ARBITER_CpuWR_In,
           MAIN_MEMORY_ARBITER_CpuAddr_InBus, MAIN_MEMORY_ARBITER_CpuWData_InBus,
           MAIN_MEMORY_ARBITER_LdReq_In, MAIN_MEMORY_ARBITER_LdWE_In,
           MAIN_MEMORY_ARBITER_LdAddr_InBus, MAIN_MEMORY_ARBITER_LdWData_InBus,
           MAIN_MEMORY_ARBITER_MemRData_InBus,
    input  MAIN_MEMORY_ARBITER_CpuACK_Out, MAIN_MEMORY_ARBITER_LdACK_Out,
           MAIN_MEMORY_ARBITER_RData_OutBus, MAIN_MEMORY_ARBITER_MemCS_Out,
           MAIN_MEMORY_ARBITER_MemWE_Out, MAIN_MEMORY_ARBITER_MemAddr_OutBus,
           MAIN_MEMORY_ARBITER_MemWData_OutBus
  );

endinterface

// File: rtl/main_memory_arbiter_rr.sv
// Two-way grant selection between CPU and loader.
// MAIN_MEMORY_ARBITER_LOADER_PRIORITY_EN: loader always wins, no last-grant state.
module main_memory_arbiter_rr
  import main_memory_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_cpu,
  input  logic   req_ld,
  input  logic   update,
  output owner_t owner_c
);

`ifdef MAIN_MEMORY_ARBITER_LOADER_PRIORITY_EN
  logic unused_c;
  assign unused_c = ^{clk, rst_n, req_cpu, update};

  // Fixed priority: loader preferred whenever it asks.
  assign owner_c = req_ld ? OWNER_LD : OWNER_CPU;
`else
  owner_t last;

  // Lone requester wins; on a tie the side not granted last wins.
  always_comb begin
    owner_c = OWNER_CPU;
    if (req_cpu && req_ld) begin
      owner_c = (last == OWNER_LD) ? OWNER_CPU : OWNER_LD;
    end else if (req_ld) begin
      owner_c = OWNER_LD;
    end
  end

  // Last-grant flop; starts at loader so the CPU takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= OWNER_LD;
    end else if (update) begin
      last <= owner_c;
    end
  end
`endif

endmodule

// File: rtl/main_memory_arbiter.sv
// Main-memory arbiter: grants CPU or loader, runs a fixed wait-state access, pulses ACK.
// Optional macro MAIN_MEMORY_ARBITER_LOADER_PRIORITY_EN selects fixed loader priority.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int unsigned DATAWIDTH_ADDR = DATAWIDTH_ADDR_DEF,
  parameter int unsigned DATAWIDTH_DATA = DATAWIDTH_DATA_DEF,
  parameter int unsigned DATAWIDTH_WAIT = DATAWIDTH_WAIT_DEF,
  parameter int unsigned WAIT_STATES    = WAIT_STATES_DEF
)(
  input  logic                  MAIN_MEMORY_ARBITER_CLOCK_50,
  input  logic                  MAIN_MEMORY_ARBITER_ResetInLow_In,
  main_memory_arbiter_if.slave  bus
);

  logic clk;
  logic rst_n;
  assign clk   = MAIN_MEMORY_ARBITER_CLOCK_50;
  assign rst_n = MAIN_MEMORY_ARBITER_ResetInLow_In;

  state_t                    state, state_nxt;
  logic [DATAWIDTH_WAIT-1:0] cnt, cnt_nxt;
  owner_t                    owner, owner_nxt;
  logic                      we_q, we_nxt;
  logic [DATAWIDTH_ADDR-1:0] addr_q, addr_nxt;
  logic [DATAWIDTH_DATA-1:0] wdata_q, wdata_nxt;
  logic [DATAWIDTH_DATA-1:0] rdata_q, rdata_nxt;
  logic                      cs_q, cs_nxt;
  logic                      mem_we_q, mem_we_nxt;
  logic                      cpu_ack_q, cpu_ack_nxt;
  logic                      ld_ack_q, ld_ack_nxt;

  logic   cpu_req_c;
  logic   ld_req_c;
  logic   grant_c;
  owner_t rr_owner_c;

  assign cpu_req_c = bus.MAIN_MEMORY_ARBITER_CpuRD_In | bus.MAIN_MEMORY_ARBITER_CpuWR_In;
  assign ld_req_c  = bus.MAIN_MEMORY_ARBITER_LdReq_In;
  assign grant_c   = (state == IDLE) && (cpu_req_c || ld_req_c);

  main_memory_arbiter_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_cpu (cpu_req_c),
    .req_ld  (ld_req_c),
    .update  (grant_c),
    .owner_c (rr_owner_c)
  );

  // Next-state and next-output decode; outputs are all registered below.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    owner_nxt   = owner;
    we_nxt      = we_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    cs_nxt      = 1'b0;
    mem_we_nxt  = 1'b0;
    cpu_ack_nxt = 1'b0;
    ld_ack_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_c) begin
          state_nxt = ACCESS;
          cnt_nxt   = DATAWIDTH_WAIT'(WAIT_STATES);
          owner_nxt = rr_owner_c;
          if (rr_owner_c == OWNER_LD) begin
            we_nxt    = bus.MAIN_MEMORY_ARBITER_LdWE_In;
            addr_nxt  = bus.MAIN_MEMORY_ARBITER_LdAddr_InBus;
            wdata_nxt = bus.MAIN_MEMORY_ARBITER_LdWData_InBus;
          end else begin
            // RD and WR together is treated as a write.
            we_nxt    = bus.MAIN_MEMORY_ARBITER_CpuWR_In;
            addr_nxt  = bus.MAIN_MEMORY_ARBITER_CpuAddr_InBus;
            wdata_nxt = bus.MAIN_MEMORY_ARBITER_CpuWData_InBus;
          end
          cs_nxt     = 1'b1;
          mem_we_nxt = we_nxt;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = ACK;
          if (!we_q) begin
            rdata_nxt = bus.MAIN_MEMORY_ARBITER_MemRData_InBus;
          end
          cpu_ack_nxt = (owner == OWNER_CPU);
          ld_ack_nxt  = (owner == OWNER_LD);
        end else begin
          cnt_nxt    = cnt - DATAWIDTH_WAIT'(1);
          cs_nxt     = 1'b1;
          mem_we_nxt = we_q;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, access latches and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWNER_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      ld_ack_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      owner     <= owner_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rdata_q   <= rdata_nxt;
      cs_q      <= cs_nxt;
      mem_we_q  <= mem_we_nxt;
      cpu_ack_q <= cpu_ack_nxt;
      ld_ack_q  <= ld_ack_nxt;
    end
  end

  assign bus.MAIN_MEMORY_ARBITER_CpuACK_Out      = cpu_ack_q;
  assign bus.MAIN_MEMORY_ARBITER_LdACK_Out       = ld_ack_q;
  assign bus.MAIN_MEMORY_ARBITER_RData_OutBus    = rdata_q;
  assign bus.MAIN_MEMORY_ARBITER_MemCS_Out       = cs_q;
  assign bus.MAIN_MEMORY_ARBITER_MemWE_Out       = mem_we_q;
  assign bus.MAIN_MEMORY_ARBITER_MemAddr_OutBus  = addr_q;
  assign bus.MAIN_MEMORY_ARBITER_MemWData_OutBus = wdata_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: instance 0 uses 2 wait states, instance 1 uses none.
module tb_main_memory_arbiter;
  import main_memory_arbiter_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          cpu_rd[2], cpu_wr[2], ld_req[2], ld_we[2];
  logic [AW-1:0] cpu_addr[2], ld_addr[2];
  logic [DW-1:0] cpu_wdata[2], ld_wdata[2];

  logic          o_cs[2], o_we[2], o_cack[2], o_lack[2];
  logic [AW-1:0] o_addr[2];
  logic [DW-1:0] o_wdata[2], o_rdata[2];

  int checks = 0;
  int fails  = 0;

  // Memory contents seen by both the model and the memory stub.
  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a, ~a};
  endfunction

  // Arbitration rule from the requester point of view.
  function automatic owner_t pick(logic c, logic l, owner_t last);
`ifdef MAIN_MEMORY_ARBITER_LOADER_PRIORITY_EN
    return (l || (c && last == OWNER_LD && 1'b0)) ? OWNER_LD : OWNER_CPU;
`else
    if (c && l) return (last == OWNER_LD) ? OWNER_CPU : OWNER_LD;
    return l ? OWNER_LD : OWNER_CPU;
`endif
  endfunction

  task automatic chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int WS = (g == 0) ? 2 : 0;

    main_memory_arbiter_if #(.DATAWIDTH_ADDR(AW), .DATAWIDTH_DATA(DW)) bus ();

    assign bus.MAIN_MEMORY_ARBITER_CpuRD_In       = cpu_rd[g];
    assign bus.MAIN_MEMORY_ARBITER_CpuWR_In       = cpu_wr[g];
    assign bus.MAIN_MEMORY_ARBITER_CpuAddr_InBus  = cpu_addr[g];
    assign bus.MAIN_MEMORY_ARBITER_CpuWData_InBus = cpu_wdata[g];
    assign bus.MAIN_MEMORY_ARBITER_LdReq_In       = ld_req[g];
    assign bus.MAIN_MEMORY_ARBITER_LdWE_In        = ld_we[g];
    assign bus.MAIN_MEMORY_ARBITER_LdAddr_InBus   = ld_addr[g];
    assign bus.MAIN_MEMORY_ARBITER_LdWData_InBus  = ld_wdata[g];
    assign bus.MAIN_MEMORY_ARBITER_MemRData_InBus = mem_word(bus.MAIN_MEMORY_ARBITER_MemAddr_OutBus);

    assign o_cs[g]    = bus.MAIN_MEMORY_ARBITER_MemCS_Out;
    assign o_we[g]    = bus.MAIN_MEMORY_ARBITER_MemWE_Out;
    assign o_cack[g]  = bus.MAIN_MEMORY_ARBITER_CpuACK_Out;
    assign o_lack[g]  = bus.MAIN_MEMORY_ARBITER_LdACK_Out;
    assign o_addr[g]  = bus.MAIN_MEMORY_ARBITER_MemAddr_OutBus;
    assign o_wdata[g] = bus.MAIN_MEMORY_ARBITER_MemWData_OutBus;
    assign o_rdata[g] = bus.MAIN_MEMORY_ARBITER_RData_OutBus;

    main_memory_arbiter #(
      .DATAWIDTH_ADDR(AW), .DATAWIDTH_DATA(DW), .DATAWIDTH_WAIT(WW), .WAIT_STATES(WS)
    ) dut (
      .MAIN_MEMORY_ARBITER_CLOCK_50    (clk),
      .MAIN_MEMORY_ARBITER_ResetInLow_In(rst_n),
      .bus                             (bus)
    );

    // Transaction timeline model: cycle k=1..WS+1 memory access, k=WS+2 ACK.
    logic          m_busy;
    int            m_k;
    owner_t        m_owner, m_last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0; m_k <= 0; m_owner <= OWNER_CPU; m_last <= OWNER_LD;
        m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
      end else if (m_busy) begin
        if (m_k == WS + 1 && !m_we) m_rdata <= mem_word(m_addr);
        if (m_k == WS + 2) m_busy <= 1'b0;
        else m_k <= m_k + 1;
      end else if (cpu_rd[g] || cpu_wr[g] || ld_req[g]) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_owner <= pick(cpu_rd[g] | cpu_wr[g], ld_req[g], m_last);
        m_last  <= pick(cpu_rd[g] | cpu_wr[g], ld_req[g], m_last);
        if (pick(cpu_rd[g] | cpu_wr[g], ld_req[g], m_last) == OWNER_LD) begin
          m_we <= ld_we[g]; m_addr <= ld_addr[g]; m_wdata <= ld_wdata[g];
        end else begin
          m_we <= cpu_wr[g]; m_addr <= cpu_addr[g]; m_wdata <= cpu_wdata[g];
        end
      end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
      automatic logic exp_cs = m_busy && (m_k <= WS + 1);
      automatic logic exp_ack = m_busy && (m_k == WS + 2);
      chk("mdl_cs", g, 64'(o_cs[g]), 64'(exp_cs));
      chk("mdl_we", g, 64'(o_we[g]), 64'(exp_cs && m_we));
      chk("mdl_cpuack", g, 64'(o_cack[g]), 64'(exp_ack && m_owner == OWNER_CPU));
      chk("mdl_ldack", g, 64'(o_lack[g]), 64'(exp_ack && m_owner == OWNER_LD));
      chk("mdl_rdata", g, 64'(o_rdata[g]), 64'(m_rdata));
      if (exp_cs) begin
        chk("mdl_addr", g, 64'(o_addr[g]), 64'(m_addr));
        chk("mdl_wdata", g, 64'(o_wdata[g]), 64'(m_wdata));
      end
    end
  end

  owner_t got[4];
  owner_t exp_rr[4];
  int     nack;

  initial begin
    for (int i = 0; i < 2; i++) begin
      cpu_rd[i] = 0; cpu_wr[i] = 0; ld_req[i] = 0; ld_we[i] = 0;
      cpu_addr[i] = '0; ld_addr[i] = '0; cpu_wdata[i] = '0; ld_wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 0, 64'(o_cs[0]), 64'(0));
    chk("rst_rdata", 0, 64'(o_rdata[0]), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // CPU read at 0x0010 with two wait states.
    @(posedge clk); #1 cpu_rd[0] = 1; cpu_addr[0] = 16'h0010;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("t1_cs", n, 64'(o_cs[0]), 64'(n >= 1 && n <= 3));
      chk("t1_cpuack", n, 64'(o_cack[0]), 64'(n == 4));
      chk("t1_ldack", n, 64'(o_lack[0]), 64'(0));
      if (n == 4) cpu_rd[0] = 0;
    end
    chk("t1_rdata", 0, 64'(o_rdata[0]), 64'h0000_0000_DEAD_BEEF);

    // Loader write at 0x0040.
    @(posedge clk); #1 ld_req[0] = 1; ld_we[0] = 1; ld_addr[0] = 16'h0040; ld_wdata[0] = 32'h12345678;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("t2_we", n, 64'(o_we[0]), 64'(n >= 1 && n <= 3));
      chk("t2_ldack", n, 64'(o_lack[0]), 64'(n == 4));
      if (n >= 1 && n <= 3) begin
        chk("t2_addr", n, 64'(o_addr[0]), 64'h0040);
        chk("t2_wdata", n, 64'(o_wdata[0]), 64'h1234_5678);
      end
      if (n == 4) begin ld_req[0] = 0; ld_we[0] = 0; end
    end
    chk("t2_rdata", 0, 64'(o_rdata[0]), 64'h0000_0000_DEAD_BEEF);

    // Continuous contention for four accesses.
`ifdef MAIN_MEMORY_ARBITER_LOADER_PRIORITY_EN
    exp_rr[0] = OWNER_LD; exp_rr[1] = OWNER_LD; exp_rr[2] = OWNER_LD; exp_rr[3] = OWNER_LD;
`else
    exp_rr[0] = OWNER_CPU; exp_rr[1] = OWNER_LD; exp_rr[2] = OWNER_CPU; exp_rr[3] = OWNER_LD;
`endif
    for (int i = 0; i < 4; i++) got[i] = OWNER_CPU;
    nack = 0;
    @(posedge clk); #1 cpu_rd[0] = 1; cpu_addr[0] = 16'h0020; ld_req[0] = 1; ld_addr[0] = 16'h0030;
    for (int n = 0; n < 40 && nack < 4; n++) begin
      @(negedge clk);
      if (o_cack[0]) begin got[nack] = OWNER_CPU; nack++; end
      else if (o_lack[0]) begin got[nack] = OWNER_LD; nack++; end
    end
    cpu_rd[0] = 0; ld_req[0] = 0;
    chk("t3_acks", 0, 64'(nack), 64'(4));
    for (int i = 0; i < 4; i++) chk("t3_grant", i, 64'(got[i]), 64'(exp_rr[i]));
    repeat (3) @(negedge clk);

    // CPU read dropped in the second access cycle still completes.
    @(posedge clk); #1 cpu_rd[0] = 1; cpu_addr[0] = 16'h0055;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("t4_cpuack", n, 64'(o_cack[0]), 64'(n == 4));
      if (n == 2) cpu_rd[0] = 0;
    end
    chk("t4_rdata", 0, 64'(o_rdata[0]), 64'h0000_0000_0055_FFAA);

    // Reset in the middle of a CPU write, then a loader read.
    @(posedge clk); #1 cpu_wr[0] = 1; cpu_addr[0] = 16'h0066; cpu_wdata[0] = 32'hCAFEF00D;
    for (int n = 0; n <= 2; n++) @(negedge clk);
    chk("t5_cs_pre", 0, 64'(o_cs[0]), 64'(1));
    #1 rst_n = 1'b0; cpu_wr[0] = 0;
    #1;
    chk("t5_cs", 0, 64'(o_cs[0]), 64'(0));
    chk("t5_we", 0, 64'(o_we[0]), 64'(0));
    chk("t5_ack", 0, 64'({o_cack[0], o_lack[0]}), 64'(0));
    chk("t5_rdata", 0, 64'(o_rdata[0]), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 ld_req[0] = 1; ld_we[0] = 0; ld_addr[0] = 16'h0070;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("t5_cs2", n, 64'(o_cs[0]), 64'(n >= 1 && n <= 3));
      chk("t5_ldack", n, 64'(o_lack[0]), 64'(n == 4));
      if (n == 4) ld_req[0] = 0;
    end
    chk("t5_rdata2", 0, 64'(o_rdata[0]), 64'h0000_0000_0070_FF8F);

    // Zero wait states, CPU holds RD across two accesses.
    @(posedge clk); #1 cpu_rd[1] = 1; cpu_addr[1] = 16'h0010;
    for (int n = 0; n <= 7; n++) begin
      @(negedge clk);
      chk("t6_cs", n, 64'(o_cs[1]), 64'(n == 1 || n == 4));
      chk("t6_cpuack", n, 64'(o_cack[1]), 64'(n == 2 || n == 5));
      if (n == 5) cpu_rd[1] = 0;
    end
    chk("t6_rdata", 1, 64'(o_rdata[1]), 64'h0000_0000_DEAD_BEEF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
